// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if -- the signal bundle for fifo_rd_stream.
// It carries the fifo_mem read-side signals and the outgoing valid/ready stream.
//   fifo_empty : fifo_mem empty flag (from the FIFO)
//   fifo_data  : fifo_mem data_out, valid the cycle after fifo_rd
//   fifo_rd    : read strobe to fifo_mem
//   m_data     : stream data
//   m_valid    : stream data valid
//   m_ready    : downstream accept
// The master modport is the controller. The slave modport is the FIFO plus the sink.
interface fifo_rd_stream_if #(
   parameter int DW = 8
);
   logic          fifo_empty;
   logic [DW-1:0] fifo_data;
   logic          fifo_rd;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;

   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output fifo_rd, m_data, m_valid
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  fifo_rd, m_data, m_valid
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream -- read-side controller for fifo_mem.
// It issues reads only when the FIFO holds data and a buffer slot is free.
// Returned words are staged in a 3-entry buffer and presented on a valid/ready stream.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   enable     : permits new FIFO reads
//   flush      : synchronous discard of buffered and in-flight words
//   bus        : FIFO read port and output stream (fifo_rd_stream_if.master)
//   xfer_count : completed stream handshakes, wraps modulo 2^CW
//   busy       : high whenever the controller is not IDLE
module fifo_rd_stream #(
   parameter int DW = 8,
   parameter int CW = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  flush,
   fifo_rd_stream_if.master      bus,
   output logic [CW-1:0]         xfer_count,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_reg;
   logic [1:0]    occ_reg;
   logic [1:0]    head_reg;
   logic [1:0]    tail_reg;
   logic          inflight_reg;
   logic [CW-1:0] xfer_count_reg;
   logic [DW-1:0] buf_mem [0:2];

   logic [2:0]    level;
   logic          rd_ok;
   logic          push;
   logic          pop;

   // Advance a ring index over the three buffer slots.
   function automatic logic [1:0] bump(input logic [1:0] p);
      bump = (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Committed slots: words already buffered plus a word still returning.
   // Capping this at 3 means a returning word always has a slot.
   assign level = {1'b0, occ_reg} + {2'b00, inflight_reg};

   assign rd_ok = enable & ~bus.fifo_empty & ~flush & (level < 3'd3) & (state_reg == RUN);
   assign bus.fifo_rd = rd_ok & ~rst;

   assign bus.m_valid = (occ_reg != 2'd0);
   assign bus.m_data  = buf_mem[head_reg];

   // A flush overrides both directions. Suppressing the push is what
   // discards the word that returns during the flush cycle.
   assign push = inflight_reg & ~flush;
   assign pop  = bus.m_valid & bus.m_ready & ~flush;

   assign xfer_count = xfer_count_reg;
   assign busy       = (state_reg != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
      end else if (push) begin
         buf_mem[tail_reg] <= bus.fifo_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         occ_reg        <= 2'd0;
         head_reg       <= 2'd0;
         tail_reg       <= 2'd0;
         inflight_reg   <= 1'b0;
         xfer_count_reg <= '0;
      end else begin
         inflight_reg <= bus.fifo_rd;
         if (flush) begin
            occ_reg   <= 2'd0;
            head_reg  <= 2'd0;
            tail_reg  <= 2'd0;
            state_reg <= enable ? RUN : IDLE;
         end else begin
            case ({push, pop})
               2'b10:   occ_reg <= occ_reg + 2'd1;
               2'b01:   occ_reg <= occ_reg - 2'd1;
               default: occ_reg <= occ_reg;
            endcase
            if (push) tail_reg <= bump(tail_reg);
            if (pop) begin
               head_reg       <= bump(head_reg);
               xfer_count_reg <= xfer_count_reg + 1'b1;
            end
            case (state_reg)
               IDLE:
                  if (enable) state_reg <= RUN;
               RUN:
                  if (!enable) state_reg <= (level != 3'd0) ? DRAIN : IDLE;
               DRAIN:
                  if (enable)
                     state_reg <= RUN;
                  else if (occ_reg == 2'd0 && !inflight_reg)
                     state_reg <= IDLE;
               default:
                  state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic flush = 1'b0;
   logic [15:0] xfer_count;
   logic busy;

   logic enable4 = 1'b0;
   logic flush4 = 1'b0;
   logic [3:0] xfer_count4;
   logic busy4;

   always #5 clk = ~clk;

   fifo_rd_stream_if #(.DW(8)) bus_if ();
   fifo_rd_stream_if #(.DW(8)) if4 ();

   fifo_rd_stream #(.DW(8), .CW(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .bus(bus_if.master), .xfer_count(xfer_count), .busy(busy)
   );

   fifo_rd_stream #(.DW(8), .CW(4)) dut4 (
      .clk(clk), .rst(rst), .enable(enable4), .flush(flush4),
      .bus(if4.master), .xfer_count(xfer_count4), .busy(busy4)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural fifo_mem (1-cycle read latency) ----------------
   logic [7:0] fmem [0:255];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   logic [7:0] fdata = 8'd0;

   assign bus_if.fifo_empty = (rd_ptr == wr_ptr);
   assign bus_if.fifo_data  = fdata;

   always @(posedge clk) begin
      if (bus_if.fifo_rd) begin
         fdata  <= fmem[rd_ptr];
         rd_ptr <= rd_ptr + 8'd1;
      end
   end

   // Second instance: an endless source and an always-ready sink.
   logic [7:0] src4 = 8'd0;
   assign if4.fifo_empty = 1'b0;
   assign if4.fifo_data  = src4;
   always @(posedge clk) if (if4.fifo_rd) src4 <= src4 + 8'd1;

   int hs4 = 0;
   always @(negedge clk) if (!rst && if4.m_valid && if4.m_ready) hs4 <= hs4 + 1;

   // ---------------- reference model: words owed to the sink ----------------
   // A word fetched in cycle c becomes visible at cycle c+2.
   // Words leave in fetch order, one per handshake.
   // A flush or reset forgets every owed word.
   typedef struct {
      logic [7:0]  data;
      int unsigned due;
   } exp_t;

   exp_t exp_q[$];
   int unsigned cyc = 0;
   int model_xfers = 0;
   int rd_pulses = 0;
   int unsigned hs_cyc [0:255];
   int unsigned rd_cyc [0:255];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic exp_valid;
      if (rst) begin
         exp_q.delete();
         model_xfers = 0;
      end else begin
         chk("xfer_count", 32'(xfer_count), 32'(model_xfers[15:0]));
         exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
         chk("m_valid", 32'(bus_if.m_valid), 32'(exp_valid));
         if (exp_valid) chk("m_data", 32'(bus_if.m_data), 32'(exp_q[0].data));
         if (bus_if.fifo_rd) begin
            chk("no_underflow", 32'(bus_if.fifo_empty), 32'd0);
            rd_cyc[rd_pulses[7:0]] = cyc;
            rd_pulses++;
            exp_q.push_back('{data: fmem[rd_ptr], due: cyc + 2});
         end
         if (flush) begin
            chk("rd_in_flush", 32'(bus_if.fifo_rd), 32'd0);
            exp_q.delete();
         end else if (bus_if.m_valid && bus_if.m_ready && exp_valid) begin
            void'(exp_q.pop_front());
            hs_cyc[model_xfers[7:0]] = cyc;
            model_xfers++;
         end
         chk("credit", 32'(exp_q.size() <= 3), 32'd1);
      end
   end

   // ---------------- stimulus ----------------
   logic toggle_ready = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
      if (toggle_ready) bus_if.m_ready = ~bus_if.m_ready;
   endtask

   task automatic fill(input logic [7:0] first);
      for (int i = 0; i < 16; i++) begin
         fmem[wr_ptr] = first + 8'(i);
         wr_ptr = wr_ptr + 8'd1;
      end
   endtask

   task automatic wait_xfers(input int target, input int budget);
      int n;
      n = 0;
      while (model_xfers < target && n < budget) begin
         step();
         n++;
      end
      if (model_xfers < target) chk("timeout_xfers", 32'd0, 32'd1);
   endtask

   task automatic wait_reads(input int target, input int budget);
      int n;
      n = 0;
      while (rd_pulses < target && n < budget) begin
         step();
         n++;
      end
      if (rd_pulses < target) chk("timeout_reads", 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      logic [7:0] left;
      bus_if.m_ready = 1'b0;
      if4.m_ready = 1'b0;

      // Reset values
      #1;
      chk("rst_fifo_rd", 32'(bus_if.fifo_rd), 32'd0);
      chk("rst_m_valid", 32'(bus_if.m_valid), 32'd0);
      chk("rst_m_data", 32'(bus_if.m_data), 32'd0);
      chk("rst_xfer_count", 32'(xfer_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (3) step();
      rst = 1'b0;
      step();

      // 1: 16 words at full rate
      fill(8'h01);
      bus_if.m_ready = 1'b1;
      enable = 1'b1;
      wait_xfers(16, 100);
      repeat (3) step();
      chk("s1_rd_pulses", 32'(rd_pulses), 32'd16);
      chk("s1_xfer_count", 32'(xfer_count), 32'd16);
      chk("s1_back_to_back", hs_cyc[15] - hs_cyc[0], 32'd15);
      chk("s1_latency", hs_cyc[0] - rd_cyc[0], 32'd2);
      enable = 1'b0;
      step(); step();
      chk("s1_busy_low", 32'(busy), 32'd0);

      // 2: m_ready toggling
      fill(8'h11);
      toggle_ready = 1'b1;
      enable = 1'b1;
      wait_xfers(32, 200);
      toggle_ready = 1'b0;
      bus_if.m_ready = 1'b1;
      step();
      chk("s2_xfer_count", 32'(xfer_count), 32'd32);
      chk("s2_rd_pulses", 32'(rd_pulses), 32'd32);
      enable = 1'b0;
      repeat (3) step();

      // 3: empty FIFO with enable high
      enable = 1'b1;
      repeat (20) step();
      chk("s3_m_valid", 32'(bus_if.m_valid), 32'd0);
      chk("s3_busy_run", 32'(busy), 32'd1);
      chk("s3_rd_pulses", 32'(rd_pulses), 32'd32);
      chk("s3_xfer_count", 32'(xfer_count), 32'd32);
      enable = 1'b0;
      repeat (2) step();

      // 4: stalled sink, enable dropped after three reads
      bus_if.m_ready = 1'b0;
      fill(8'h21);
      enable = 1'b1;
      wait_reads(35, 50);
      enable = 1'b0;
      repeat (3) step();
      chk("s4_busy_drain", 32'(busy), 32'd1);
      chk("s4_m_data", 32'(bus_if.m_data), 32'h21);
      chk("s4_rd_pulses", 32'(rd_pulses), 32'd35);
      bus_if.m_ready = 1'b1;
      wait_xfers(35, 50);
      step(); step();
      chk("s4_busy_idle", 32'(busy), 32'd0);
      chk("s4_fifo_left", 32'(wr_ptr - rd_ptr), 32'd13);
      chk("s4_xfer_count", 32'(xfer_count), 32'd35);

      // 5: flush with occ=2, inflight=1
      bus_if.m_ready = 1'b0;
      enable = 1'b1;
      wait_reads(38, 50);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("s5_m_valid_after_flush", 32'(bus_if.m_valid), 32'd0);
      chk("s5_busy", 32'(busy), 32'd1);
      bus_if.m_ready = 1'b1;
      wait_xfers(45, 100);
      repeat (3) step();
      chk("s5_xfer_count", 32'(xfer_count), 32'd45);
      chk("s5_rd_pulses", 32'(rd_pulses), 32'd48);
      enable = 1'b0;
      repeat (3) step();

      // 6: CW=4 instance wraps after 17 transfers
      if4.m_ready = 1'b1;
      enable4 = 1'b1;
      n = 0;
      while (hs4 < 17 && n < 100) begin
         step();
         n++;
      end
      if4.m_ready = 1'b0;
      enable4 = 1'b0;
      chk("cw4_hs", 32'(hs4), 32'd17);
      chk("cw4_xfer_count", 32'(xfer_count4), 32'd1);

      // 7: asynchronous reset mid-stream
      fill(8'h31);
      bus_if.m_ready = 1'b1;
      enable = 1'b1;
      repeat (6) step();
      @(posedge clk);
      #3;
      chk("pre_rst_m_valid", 32'(bus_if.m_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_fifo_rd", 32'(bus_if.fifo_rd), 32'd0);
      chk("arst_m_valid", 32'(bus_if.m_valid), 32'd0);
      chk("arst_m_data", 32'(bus_if.m_data), 32'd0);
      chk("arst_xfer_count", 32'(xfer_count), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      left = wr_ptr - rd_ptr;
      n = 0;
      while ((rd_ptr != wr_ptr || exp_q.size() != 0) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) chk("timeout_rst_drain", 32'd0, 32'd1);
      step();
      chk("s7_xfer_count", 32'(xfer_count), 32'(left));
      enable = 1'b0;
      repeat (3) step();
      chk("s7_busy_idle", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
